// File: rtl/riscv_fetch_stage.sv
// ---------------------------------------------------------------------------
// riscv_fetch_stage
//   Instruction fetch stage plus the IF/ID pipeline register. The stage holds
//   the fetch PC and fetches over a req/ack instruction-memory handshake. It
//   applies execute-stage redirects and the decode stall/flush controls, then
//   presents instr / pc / pc+4 / valid to decode.
//
// Ports
//   iclk, irst     clock; synchronous active-high reset
//   ipc_src        execute redirect strobe (taken branch / jump)
//   ipc_target_e   redirect target (bits [1:0] forced to zero)
//   istall_d       hold the IF/ID register
//   iflush_d       replace the IF/ID contents with a bubble
//   oimem_req      fetch request (low during reset and in HOLD)
//   oimem_addr     fetch address, always the current fetch PC
//   iimem_ack      fetch data valid this cycle (same-cycle ack allowed)
//   iimem_rdata    fetched instruction word
//   oinstr_d       IF/ID instruction (NOP when it holds a bubble)
//   opc_d          IF/ID PC
//   opc_plus4_d    IF/ID PC+4
//   ovalid_d       IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module riscv_fetch_stage #(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic            iclk,
   input  logic            irst,
   input  logic            ipc_src,
   input  logic [XLEN-1:0] ipc_target_e,
   input  logic            istall_d,
   input  logic            iflush_d,
   output logic            oimem_req,
   output logic [XLEN-1:0] oimem_addr,
   input  logic            iimem_ack,
   input  logic [31:0]     iimem_rdata,
   output logic [31:0]     oinstr_d,
   output logic [XLEN-1:0] opc_d,
   output logic [XLEN-1:0] opc_plus4_d,
   output logic            ovalid_d
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   // FETCH: request outstanding at r_pc_f.
   // DROP : a redirect arrived before the ack; finish the handshake, then
   //        discard the data and jump to the pending target.
   // HOLD : fetched word parked while decode stalls; no request issued.
   typedef enum logic [1:0] {S_FETCH, S_DROP, S_HOLD} state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [XLEN-1:0] r_pc_f;
   logic [XLEN-1:0] r_pending;
   logic [31:0]     r_hold;

   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_pc_next;
   logic            w_deliver;
   logic [31:0]     w_deliver_instr;
   logic            w_pending_we;
   logic            w_hold_we;

   // Targets are word aligned; masking keeps every input bit in use.
   assign w_target   = ipc_target_e & ~XLEN'(3);
   assign w_pc_plus4 = r_pc_f + XLEN'(4);   // wraps modulo 2^XLEN
   assign oimem_addr = r_pc_f;

   // ---- FSM: state register ----------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge iclk) begin
      if (irst) r_state <= S_FETCH;
      else      r_state <= w_next_state;
   end

   // ---- FSM: next-state logic --------------------------------------------
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_FETCH: begin
            if (iimem_ack && !ipc_src && istall_d) w_next_state = S_HOLD;
            else if (!iimem_ack && ipc_src)        w_next_state = S_DROP;
         end
         S_DROP:  if (iimem_ack)             w_next_state = S_FETCH;
         S_HOLD:  if (ipc_src || !istall_d)  w_next_state = S_FETCH;
         default:                            w_next_state = S_FETCH;
      endcase
   end

   // ---- FSM: outputs -------------------------------------------------------
   always_comb begin
      oimem_req = !irst && (r_state != S_HOLD);
   end

   // ---- Datapath control: PC update, delivery, side registers -------------
   always_comb begin
      w_pc_next       = r_pc_f;
      w_deliver       = 1'b0;
      w_deliver_instr = iimem_rdata;
      w_pending_we    = 1'b0;
      w_hold_we       = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            if (iimem_ack) begin
               if (ipc_src) begin
                  w_pc_next = w_target;           // fetched word discarded
               end else if (!istall_d) begin
                  w_deliver = 1'b1;
                  w_pc_next = w_pc_plus4;
               end else begin
                  w_hold_we = 1'b1;               // park word, PC stays
               end
            end else if (ipc_src) begin
               w_pending_we = 1'b1;
            end
         end
         S_DROP: begin
            // A redirect during DROP replaces the pending one (last wins).
            w_pending_we = ipc_src;
            if (iimem_ack) w_pc_next = ipc_src ? w_target : r_pending;
         end
         S_HOLD: begin
            if (ipc_src) begin
               w_pc_next = w_target;
            end else if (!istall_d) begin
               w_deliver       = 1'b1;
               w_deliver_instr = r_hold;
               w_pc_next       = w_pc_plus4;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (irst) r_pc_f <= RESET_PC;
      else      r_pc_f <= w_pc_next;
   end

   // NOTE: the pending-target and hold registers carry no reset; they are
   // only read in the state that follows their own write enable.
   always_ff @(posedge iclk) begin
      if (w_pending_we) r_pending <= w_target;
      if (w_hold_we)    r_hold    <= iimem_rdata;
   end

   // ---- IF/ID register: reset > flush > stall > load/bubble ---------------
   always_ff @(posedge iclk) begin
      if (irst || iflush_d) begin
         oinstr_d    <= NOP;
         opc_d       <= '0;
         opc_plus4_d <= '0;
         ovalid_d    <= 1'b0;
      end else if (!istall_d) begin
         if (w_deliver) begin
            oinstr_d    <= w_deliver_instr;
            opc_d       <= r_pc_f;
            opc_plus4_d <= w_pc_plus4;
            ovalid_d    <= 1'b1;
         end else begin
            oinstr_d    <= NOP;
            opc_d       <= '0;
            opc_plus4_d <= '0;
            ovalid_d    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_riscv_fetch_stage
//   Self-checking bench for riscv_fetch_stage. Instruction memory returns an
//   address-tagged word; every fetch that must reach decode is pushed to a
//   scoreboard queue and popped when IF/ID presents a new valid instruction.
// ---------------------------------------------------------------------------
module tb_riscv_fetch_stage;

   logic        iclk = 1'b0;
   logic        irst;
   logic        ipc_src;
   logic [31:0] ipc_target_e;
   logic        istall_d;
   logic        iflush_d;
   logic        oimem_req;
   logic [31:0] oimem_addr;
   logic        iimem_ack;
   logic [31:0] iimem_rdata;
   logic [31:0] oinstr_d;
   logic [31:0] opc_d;
   logic [31:0] opc_plus4_d;
   logic        ovalid_d;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic last_stall = 1'b0;

   riscv_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .iclk         (iclk),
      .irst         (irst),
      .ipc_src      (ipc_src),
      .ipc_target_e (ipc_target_e),
      .istall_d     (istall_d),
      .iflush_d     (iflush_d),
      .oimem_req    (oimem_req),
      .oimem_addr   (oimem_addr),
      .iimem_ack    (iimem_ack),
      .iimem_rdata  (iimem_rdata),
      .oinstr_d     (oinstr_d),
      .opc_d        (opc_d),
      .opc_plus4_d  (opc_plus4_d),
      .ovalid_d     (ovalid_d)
   );

   always #5 iclk = ~iclk;

   function automatic logic [31:0] tag(input logic [31:0] a);
      return a ^ 32'h5A00_0001;
   endfunction

   assign iimem_rdata = tag(oimem_addr);

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.instr = tag(pc);
      e.pc    = pc;
      e.pc4   = pc + 32'd4;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic drive(input logic ack, input logic src, input logic [31:0] tgt,
                        input logic stall, input logic flush);
      iimem_ack    = ack;
      ipc_src      = src;
      ipc_target_e = tgt;
      istall_d     = stall;
      iflush_d     = flush;
      #1;
   endtask

   task automatic do_reset();
      irst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("req_in_rst", 32'(oimem_req), 32'd0);
      tick();
      tick();
      check("rst_instr", oinstr_d, 32'h0000_0013);
      check("rst_pc", opc_d, 32'h0);
      check("rst_pc4", opc_plus4_d, 32'h0);
      check("rst_valid", 32'(ovalid_d), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
      irst = 1'b0;
      #1;
      check("rst_addr", oimem_addr, 32'h0);
   endtask

   // IF/ID took a new value at the last edge unless that edge was a stall.
   always @(posedge iclk) last_stall <= istall_d;

   always @(negedge iclk) begin
      if (ovalid_d && !last_stall) begin
         if (sb.size() == 0) begin
            check("unexp_valid", 32'(ovalid_d), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("sb_instr", oinstr_d, mon_e.instr);
            check("sb_pc", opc_d, mon_e.pc);
            check("sb_pc4", opc_plus4_d, mon_e.pc4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] pc;
      logic        ack;

      // 1: zero-wait ack streams 0,4,8..
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         check("t1_req", 32'(oimem_req), 32'd1);
         check("t1_addr", oimem_addr, 32'(i * 4));
         push_exp(32'(i * 4));
         tick();
         check("t1_valid", 32'(ovalid_d), 32'd1);
      end

      // 2: ack on every 3rd cycle; address held, bubbles in between
      do_reset();
      pc = 32'h0;
      for (int k = 0; k < 12; k++) begin
         ack = (k % 3 == 0);
         drive(ack, 1'b0, 32'h0, 1'b0, 1'b0);
         check("t2_addr", oimem_addr, pc);
         if (ack) push_exp(pc);
         tick();
         check("t2_valid", 32'(ovalid_d), 32'(ack));
         if (ack) pc = pc + 32'd4;
      end

      // 3: redirect before ack at 0x8; last redirect wins, low bits masked
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         push_exp(32'(i * 4));
         tick();
      end
      drive(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
      check("t3_addr_a", oimem_addr, 32'h8);
      tick();
      check("t3_bub_a", 32'(ovalid_d), 32'd0);
      drive(1'b0, 1'b1, 32'h103, 1'b0, 1'b0);
      check("t3_drop_req", 32'(oimem_req), 32'd1);
      check("t3_drop_addr", oimem_addr, 32'h8);
      tick();
      check("t3_bub_b", 32'(ovalid_d), 32'd0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t3_addr_c", oimem_addr, 32'h8);
      tick();
      check("t3_drop_bub", 32'(ovalid_d), 32'd0);
      check("t3_tgt_addr", oimem_addr, 32'h100);
      push_exp(32'h100);
      tick();
      push_exp(32'h104);
      tick();

      // 4: stall for 3 cycles coinciding with ack at 0xC
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         push_exp(32'(i * 4));
         tick();
      end
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      check("t4_addr", oimem_addr, 32'hC);
      tick();
      for (int j = 0; j < 2; j++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         check("t4_hold_req", 32'(oimem_req), 32'd0);
         check("t4_hold_instr", oinstr_d, tag(32'h8));
         check("t4_hold_pc", opc_d, 32'h8);
         check("t4_hold_valid", 32'(ovalid_d), 32'd1);
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t4_hold_req3", 32'(oimem_req), 32'd0);
      push_exp(32'hC);
      tick();
      check("t4_rel_pc", opc_d, 32'hC);
      check("t4_rel_pc4", opc_plus4_d, 32'h10);
      check("t4_next_addr", oimem_addr, 32'h10);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      push_exp(32'h10);
      tick();

      // 5: flush alone keeps pc; redirect+flush with ack at 0x10
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         push_exp(32'(i * 4));
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      check("t5_flush_pc", oimem_addr, 32'h10);
      check("t5_flush_bub", 32'(ovalid_d), 32'd0);
      drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b1);
      check("t5_addr", oimem_addr, 32'h10);
      tick();
      check("t5_bub_valid", 32'(ovalid_d), 32'd0);
      check("t5_bub_instr", oinstr_d, 32'h0000_0013);
      check("t5_tgt_addr", oimem_addr, 32'h40);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      push_exp(32'h40);
      tick();

      // 6: reset mid-DROP, then PC wrap at 0xFFFF_FFFC
      do_reset();
      drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("t6_drop_addr", oimem_addr, 32'h0);
      irst = 1'b1;
      #1;
      check("t6_rst_req", 32'(oimem_req), 32'd0);
      tick();
      irst = 1'b0;
      #1;
      check("t6_post_addr", oimem_addr, 32'h0);
      check("t6_post_req", 32'(oimem_req), 32'd1);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      push_exp(32'h0);
      tick();
      check("t6_post_valid", 32'(ovalid_d), 32'd1);
      drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
      tick();
      check("t6_top_addr", oimem_addr, 32'hFFFF_FFFC);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      push_exp(32'hFFFF_FFFC);
      tick();
      check("t6_wrap_pc4", opc_plus4_d, 32'h0);
      check("t6_wrap_addr", oimem_addr, 32'h0);
      push_exp(32'h0);
      tick();

      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      check("sb_final", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
